tlk2711_nch_hub: RTL

- Register-bus fabric and interrupt aggregator for NUM_CH tlk2711 channels.
- Sits between the PS register bus and the per-channel tlk2711_top instances, all on ps_clk.
- Decodes each channel's address window and strips the base, leaving a local offset.
- Pipelines read returns with fixed latency and a valid strobe.
- Owns hub registers for interrupt pending/enable/raw, and drives one combined PS interrupt plus per-channel summaries.

---
 rtl/tlk2711_nch_hub.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/tlk2711_nch_hub.sv
// Register-bus fabric and interrupt aggregator for NUM_CH tlk2711 channels.
// Decodes channel/hub windows, pipelines reads at fixed latency 3, owns the IRQ registers.
module tlk2711_nch_hub #(
  parameter int unsigned NUM_CH         = 4,
  parameter logic [15:0] CH_ADDR_STRIDE = 16'h0100,
  parameter logic [15:0] CH_ADDR_MASK   = 16'h00ff,
  parameter logic [15:0] HUB_ADDR_BASE  = 16'hF000,
  parameter logic [15:0] HUB_VERSION    = 16'h0002
) (
  input  logic                  ps_clk,
  input  logic                  ps_rst,
  input  logic                  i_reg_wen,
  input  logic [15:0]           i_reg_waddr,
  input  logic [63:0]           i_reg_wdata,
  input  logic                  i_reg_ren,
  input  logic [15:0]           i_reg_raddr,
  output logic [63:0]           o_reg_rdata,
  output logic                  o_reg_rvalid,
  output logic [NUM_CH-1:0]     o_ch_reg_wen,
  output logic [15:0]           o_ch_reg_waddr,
  output logic [63:0]           o_ch_reg_wdata,
  output logic [NUM_CH-1:0]     o_ch_reg_ren,
  output logic [15:0]           o_ch_reg_raddr,
  input  logic [NUM_CH*64-1:0]  i_ch_reg_rdata,
  input  logic [NUM_CH*3-1:0]   i_ch_irq,
  output logic [NUM_CH-1:0]     o_ch_irq,
  output logic                  o_irq
);

  localparam int unsigned IrqW = 3 * NUM_CH;
  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {TagNone = 2'd0, TagCh = 2'd1, TagHub = 2'd2} tag_e;

  typedef struct packed {
    tag_e            tag;
    logic [IdxW-1:0] idx;
  } dec_t;

  // Hub window wins over any overlapping channel window.
  function automatic dec_t decode(input logic [15:0] addr);
    dec_t d;
    d.tag = TagNone;
    d.idx = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if ((addr & ~CH_ADDR_MASK) == 16'(k * CH_ADDR_STRIDE)) begin
        d.tag = TagCh;
        d.idx = IdxW'(k);
      end
    end
    if ((addr & 16'hff00) == HUB_ADDR_BASE) d.tag = TagHub;
    return d;
  endfunction

  dec_t wdec, rdec;

  logic [NUM_CH-1:0] ch_wen_d, ch_wen_q, ch_ren_d, ch_ren_q;
  logic [15:0]       ch_waddr_d, ch_waddr_q, ch_raddr_d, ch_raddr_q;
  logic [63:0]       ch_wdata_d, ch_wdata_q;
  logic              hub_wen_d, hub_wen_q;
  logic [7:0]        hub_woff_d, hub_woff_q;
  logic [63:0]       hub_wdata_d, hub_wdata_q;

  logic              rv1_d, rv1_q, rv2_d, rv2_q;
  tag_e              tag1_d, tag1_q, tag2_d, tag2_q;
  logic [IdxW-1:0]   idx1_d, idx1_q, idx2_d, idx2_q;
  logic [7:0]        hoff1_d, hoff1_q;
  logic [63:0]       hub_rdata2_d, hub_rdata2_q, ch_sel;
  logic [63:0]       rdata_d, rdata_q;
  logic              rvalid_d, rvalid_q;

  logic [IrqW-1:0]   irq_prev_q, pend_d, pend_q, en_d, en_q, w1c;
  logic [NUM_CH-1:0] ch_irq_d, ch_irq_q;
  logic              irq_d, irq_q;

  always_comb begin
    wdec        = decode(i_reg_waddr);
    ch_wen_d    = '0;
    ch_waddr_d  = '0;
    ch_wdata_d  = '0;
    hub_wen_d   = 1'b0;
    hub_woff_d  = '0;
    hub_wdata_d = '0;
    if (i_reg_wen) begin
      case (wdec.tag)
        TagCh: begin
          ch_wen_d[wdec.idx] = 1'b1;
          ch_waddr_d         = i_reg_waddr & CH_ADDR_MASK;
          ch_wdata_d         = i_reg_wdata;
        end
        TagHub: begin
          hub_wen_d   = 1'b1;
          hub_woff_d  = i_reg_waddr[7:0];
          hub_wdata_d = i_reg_wdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdec       = decode(i_reg_raddr);
    rv1_d      = i_reg_ren;
    tag1_d     = i_reg_ren ? rdec.tag : TagNone;
    idx1_d     = rdec.idx;
    hoff1_d    = i_reg_raddr[7:0];
    ch_ren_d   = '0;
    ch_raddr_d = '0;
    if (i_reg_ren && rdec.tag == TagCh) begin
      ch_ren_d[rdec.idx] = 1'b1;
      ch_raddr_d         = i_reg_raddr & CH_ADDR_MASK;
    end
  end

  // Hub data is captured one stage early so it lines up with the channel return.
  always_comb begin
    rv2_d        = rv1_q;
    tag2_d       = tag1_q;
    idx2_d       = idx1_q;
    hub_rdata2_d = '0;
    if (tag1_q == TagHub) begin
      case (hoff1_q)
        8'h00:   hub_rdata2_d = 64'(pend_q);
        8'h08:   hub_rdata2_d = 64'(en_q);
        8'h10:   hub_rdata2_d = 64'(i_ch_irq);
        8'h18:   hub_rdata2_d = {32'h0, 16'(NUM_CH), HUB_VERSION};
        default: hub_rdata2_d = '0;
      endcase
    end
  end

  always_comb begin
    ch_sel = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (idx2_q == IdxW'(k)) ch_sel = i_ch_reg_rdata[64*k +: 64];
    end
    rvalid_d = rv2_q;
    rdata_d  = '0;
    if (rv2_q) begin
      case (tag2_q)
        TagCh:   rdata_d = ch_sel;
        TagHub:  rdata_d = hub_rdata2_q;
        default: rdata_d = '0;
      endcase
    end
  end

  // A new rising edge beats a simultaneous write-1-to-clear.
  always_comb begin
    w1c    = (hub_wen_q && hub_woff_q == 8'h00) ? hub_wdata_q[IrqW-1:0] : '0;
    pend_d = (pend_q & ~w1c) | (i_ch_irq & ~irq_prev_q);
    en_d   = (hub_wen_q && hub_woff_q == 8'h08) ? hub_wdata_q[IrqW-1:0] : en_q;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ch_irq_d[k] = |(pend_q[3*k +: 3] & en_q[3*k +: 3]);
    end
    irq_d = |ch_irq_d;
  end

  always_ff @(posedge ps_clk or posedge ps_rst) begin
    if (ps_rst) begin
      ch_wen_q     <= '0;
      ch_waddr_q   <= '0;
      ch_wdata_q   <= '0;
      hub_wen_q    <= 1'b0;
      hub_woff_q   <= '0;
      hub_wdata_q  <= '0;
      ch_ren_q     <= '0;
      ch_raddr_q   <= '0;
      rv1_q        <= 1'b0;
      tag1_q       <= TagNone;
      idx1_q       <= '0;
      hoff1_q      <= '0;
      rv2_q        <= 1'b0;
      tag2_q       <= TagNone;
      idx2_q       <= '0;
      hub_rdata2_q <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      irq_prev_q   <= '0;
      pend_q       <= '0;
      en_q         <= '0;
      ch_irq_q     <= '0;
      irq_q        <= 1'b0;
    end else begin
      ch_wen_q     <= ch_wen_d;
      ch_waddr_q   <= ch_waddr_d;
      ch_wdata_q   <= ch_wdata_d;
      hub_wen_q    <= hub_wen_d;
      hub_woff_q   <= hub_woff_d;
      hub_wdata_q  <= hub_wdata_d;
      ch_ren_q     <= ch_ren_d;
      ch_raddr_q   <= ch_raddr_d;
      rv1_q        <= rv1_d;
      tag1_q       <= tag1_d;
      idx1_q       <= idx1_d;
      hoff1_q      <= hoff1_d;
      rv2_q        <= rv2_d;
      tag2_q       <= tag2_d;
      idx2_q       <= idx2_d;
      hub_rdata2_q <= hub_rdata2_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      irq_prev_q   <= i_ch_irq;
      pend_q       <= pend_d;
      en_q         <= en_d;
      ch_irq_q     <= ch_irq_d;
      irq_q        <= irq_d;
    end
  end

  assign o_ch_reg_wen   = ch_wen_q;
  assign o_ch_reg_waddr = ch_waddr_q;
  assign o_ch_reg_wdata = ch_wdata_q;
  assign o_ch_reg_ren   = ch_ren_q;
  assign o_ch_reg_raddr = ch_raddr_q;
  assign o_reg_rdata    = rdata_q;
  assign o_reg_rvalid   = rvalid_q;
  assign o_ch_irq       = ch_irq_q;
  assign o_irq          = irq_q;

endmodule
